silu_grad_pwl: RTL and testbench

- Backward-pass companion to the forward SiLU PWL activation.
- Computes dx = dy * silu'(x) per element for training and fine-tuning datapaths.
- silu'(x) comes from a 16-segment piecewise-constant table. One multiply, then round and saturate.
- 3-stage valid/ready pipeline. Sits between the upstream-gradient stream and the weight-gradient accumulator. Uses the same Q6.9 fixed-point format as the forward unit (0x0200 = 1.0).

---
 rtl/silu_pkg.sv | 29 ++
 rtl/silu_grad_lut.sv | 28 ++
 rtl/silu_grad_pwl.sv | 133 +++++++++++++
 tb/tb_silu_grad_pwl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// silu_pkg : Q6.9 format constants and silu' table shared by SiLU units
// Rev 1.0
// ----------------------------------------------------------------------------
package silu_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 9;
  localparam int G_W       = 12;
  localparam int P_W       = DATA_W + G_W;

  localparam logic signed [DATA_W-1:0] X_MIN  = 16'shF000;
  localparam logic signed [DATA_W-1:0] X_MAX  = 16'sh1000;
  localparam logic signed [G_W-1:0]    G_HIGH = 12'sd512;

  // silu'(x) at the midpoint of each 1.0-wide segment over [-8, 8)
  localparam logic signed [G_W-1:0] TABLE [16] = '{
    -12'sd2,   -12'sd4,   -12'sd9,   -12'sd19,
    -12'sd36,  -12'sd51,  -12'sd21,   12'sd133,
     12'sd379,  12'sd533,  12'sd563,  12'sd548,
     12'sd531,  12'sd521,  12'sd516,  12'sd514
  };

  localparam logic signed [P_W-1:0] DX_MAX = P_W'(32767);
  localparam logic signed [P_W-1:0] DX_MIN = -P_W'(32768);

endpackage
`default_nettype wire

// File: rtl/silu_grad_lut.sv
`default_nettype none
// ----------------------------------------------------------------------------
// silu_grad_lut : combinational x -> silu'(x) lookup with clamping, Q2.9 out
// Rev 1.0
// ----------------------------------------------------------------------------
module silu_grad_lut
  import silu_pkg::*;
(
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [G_W-1:0]    g_o
);

  logic [3:0] seg;

  // Biased integer part of x: -8..7 maps onto 0..15
  assign seg = {~x_i[FRAC_BITS+3], x_i[FRAC_BITS+2:FRAC_BITS]};

  always_comb begin
    g_o = TABLE[seg];
    if (x_i < X_MIN) begin
      g_o = '0;
    end else if (x_i >= X_MAX) begin
      g_o = G_HIGH;
    end
  end

endmodule
`default_nettype wire

// File: rtl/silu_grad_pwl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// silu_grad_pwl : 3-stage pipelined dx = dy * silu'(x), rounded and saturated
// Optional saturation counter port sat_count with SILU_GRAD_STATS_EN. Rev 1.0
// ----------------------------------------------------------------------------
module silu_grad_pwl
  import silu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_dy,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_dx,
  output logic                     out_last
`ifdef SILU_GRAD_STATS_EN
  ,
  output logic [DATA_W-1:0]        sat_count
`endif
);

  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic ld1, ld2, ld3;

  logic signed [G_W-1:0]    g1_q;
  logic signed [DATA_W-1:0] dy1_q;
  logic                     last1_q;
  logic signed [P_W-1:0]    p2_q;
  logic                     last2_q;
  logic signed [DATA_W-1:0] dx3_q;
  logic                     last3_q;

  logic signed [G_W-1:0]    g_lut;
  logic signed [P_W-1:0]    prod;
  logic signed [P_W-1:0]    rnd;
  logic signed [P_W-1:0]    r;
  logic                     clip_hi, clip_lo;
  logic signed [DATA_W-1:0] dx_d;

  silu_grad_lut u_lut (
    .x_i (in_x),
    .g_o (g_lut)
  );

  // A stage loads when empty or when its successor is loading
  assign ld3      = ~v3_q | out_ready;
  assign ld2      = ~v2_q | ld3;
  assign ld1      = ~v1_q | ld2;
  assign in_ready = ld1;

  assign v1_d = ld1 ? in_valid : v1_q;
  assign v2_d = ld2 ? v1_q     : v2_q;
  assign v3_d = ld3 ? v2_q     : v3_q;

  assign prod    = P_W'(dy1_q) * P_W'(g1_q);
  assign rnd     = p2_q + P_W'(1 << (FRAC_BITS - 1));
  assign r       = rnd >>> FRAC_BITS;
  assign clip_hi = r > DX_MAX;
  assign clip_lo = r < DX_MIN;

  always_comb begin
    dx_d = r[DATA_W-1:0];
    if (clip_hi) begin
      dx_d = 16'sh7FFF;
    end else if (clip_lo) begin
      dx_d = 16'sh8000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      g1_q    <= '0;
      dy1_q   <= '0;
      last1_q <= 1'b0;
      p2_q    <= '0;
      last2_q <= 1'b0;
      dx3_q   <= '0;
      last3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (ld1 && in_valid) begin
        g1_q    <= g_lut;
        dy1_q   <= in_dy;
        last1_q <= in_last;
      end
      if (ld2 && v1_q) begin
        p2_q    <= prod;
        last2_q <= last1_q;
      end
      if (ld3 && v2_q) begin
        dx3_q   <= dx_d;
        last3_q <= last2_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_dx    = dx3_q;
  assign out_last  = last3_q;

`ifdef SILU_GRAD_STATS_EN
  logic                sat3_q;
  logic [DATA_W-1:0]   sat_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat3_q    <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      if (ld3 && v2_q) begin
        sat3_q <= clip_hi | clip_lo;
      end
      if (v3_q && out_ready && sat3_q && (sat_cnt_q != '1)) begin
        sat_cnt_q <= sat_cnt_q + 1'b1;
      end
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_silu_grad_pwl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_silu_grad_pwl : randomized and directed checks of silu_grad_pwl against
// an arithmetic reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_silu_grad_pwl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_x = '0;
  logic [15:0] in_dy = '0;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_dx;
`ifdef SILU_GRAD_STATS_EN
  logic [15:0] sat_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] dx;
    logic        last;
    bit          sat;
  } exp_t;

  exp_t q[$];
  int   sat_m = 0;
  int   TBL[16] = '{-2, -4, -9, -19, -36, -51, -21, 133,
                    379, 533, 563, 548, 531, 521, 516, 514};

  always #5 clk = ~clk;

  silu_grad_pwl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_dy     (in_dy),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dx    (out_dx),
    .out_last  (out_last)
`ifdef SILU_GRAD_STATS_EN
    ,
    .sat_count (sat_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // dx = floor((dy*g + 256) / 512), clipped to int16
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] dy, input logic last);
    int   xi, di, g, r;
    exp_t e;
    xi = int'($signed(x));
    di = int'($signed(dy));
    if (xi < -4096)     g = 0;
    else if (xi >= 4096) g = 512;
    else                g = TBL[(xi + 4096) / 512];
    r = (di * g + 256) >>> 9;
    e.sat = (r > 32767) || (r < -32768);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    e.dx   = r[15:0];
    e.last = last;
    return e;
  endfunction

  logic [15:0] hold_dx;
  logic        hold_last;
  bit          stalled = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      q.delete();
      sat_m   = 0;
      stalled = 0;
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 3) || out_ready});
      if (q.size() == 0) chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
      if (stalled) begin
        chk("hold_dx", {16'd0, out_dx}, {16'd0, hold_dx});
        chk("hold_last", {31'd0, out_last}, {31'd0, hold_last});
      end
`ifdef SILU_GRAD_STATS_EN
      chk("sat_count", {16'd0, sat_count}, sat_m);
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_out: got dx %0h, expected no beat", out_dx);
        end else begin
          e = q.pop_front();
          chk("out_dx", {16'd0, out_dx}, {16'd0, e.dx});
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
          if (e.sat && sat_m < 65535) sat_m++;
        end
      end
      stalled   = out_valid && !out_ready;
      hold_dx   = out_dx;
      hold_last = out_last;
      if (in_valid && in_ready) q.push_back(model(in_x, in_dy, in_last));
    end
  end

  // All tasks start and end just after a rising edge
  task automatic send(input logic [15:0] x, input logic [15:0] dy, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_dy    = dy;
    in_last  = last;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        $display("FAIL send_timeout: got in_ready 0, expected 1");
        $fatal(1, "input stalled");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_pin(input string name, input logic [15:0] x, input logic [15:0] dy,
                          input logic [15:0] lit);
    exp_t m;
    m = model(x, dy, 1'b0);
    chk(name, {16'd0, m.dx}, {16'd0, lit});
    send(x, dy, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic chk_latency(input string name);
    @(negedge clk); chk({name, "_c1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk({name, "_c2"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk({name, "_c3"}, {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_x();
    logic [15:0] b[6];
    b = '{16'hF000, 16'hEFFF, 16'h1000, 16'h0FFF, 16'h8000, 16'h7FFF};
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'($signed($urandom_range(0, 16'h2400)) - 32'sh1200);
      2:       return b[$urandom_range(0, 5)];
      default: return 16'($signed($urandom_range(0, 1023)) - 32'sd512);
    endcase
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int idx, acc, cyc;
    logic [15:0] bx[8];
    logic [15:0] bdy[8];

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_dx", {16'd0, out_dx}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SILU_GRAD_STATS_EN
    chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
`endif
    @(posedge clk); #1;

    out_ready = 1'b1;
    send_pin("pin_x0", 16'h0000, 16'h0200, 16'h017B);
    chk_latency("lat_x0");

    send_pin("pin_xmin", 16'hF000, 16'h0200, 16'hFFFE);
    send_pin("pin_below", 16'hEFFF, 16'h0200, 16'h0000);
    send_pin("pin_xmax", 16'h1000, 16'h1234, 16'h1234);
    send_pin("pin_top_seg", 16'h0FFF, 16'h0200, 16'h0202);
    send_pin("pin_sat_hi", 16'h0500, 16'h7FFF, 16'h7FFF);
    send_pin("pin_sat_lo", 16'h0500, 16'h8000, 16'h8000);
    drain();
`ifdef SILU_GRAD_STATS_EN
    chk("sat_count_2", {16'd0, sat_count}, 32'd2);
`endif

    // 8-beat burst with the output stalled for cycles 2..7
    for (int i = 0; i < 8; i++) begin
      bx[i]  = rand_x();
      bdy[i] = 16'($urandom);
    end
    idx = 0;
    for (int c = 1; c <= 40 && idx < 8; c++) begin
      out_ready = !(c >= 2 && c <= 7);
      in_valid  = 1'b1;
      in_x      = bx[idx];
      in_dy     = bdy[idx];
      in_last   = (idx == 7);
      @(negedge clk);
      if (c == 5) begin
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_accepted", idx, 32'd3);
      end
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_all_sent", idx, 32'd8);
    drain();

    // Random traffic
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = rand_x();
      in_dy     = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000)
                                              : 16'($urandom);
      in_last   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_beats", acc, 32'd10000);
    drain();

    // Reset with three beats in flight
    out_ready = 1'b0;
    send(16'h0500, 16'h7FFF, 1'b0);
    send(16'h0000, 16'h0400, 1'b0);
    send(16'h0300, 16'h8000, 1'b1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SILU_GRAD_STATS_EN
    chk("rst2_sat_count", {16'd0, sat_count}, 32'd0);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_pin("pin_post_rst", 16'h0200, 16'h0200, 16'h0215);
    chk_latency("lat_post_rst");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
